// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative radix-2 multiply/divide unit with HI/LO result registers
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e             state_q;
  logic               is_div_q, neg_res_q, neg_rem_q, dz_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [5:0]         cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q, div_zero_q;

  logic               is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, rem_s, rem_diff;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_n;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & a[WIDTH-1];
  assign b_neg     = is_signed & b[WIDTH-1];
  assign a_mag     = a_neg ? (~a + 1'b1) : a;
  assign b_mag     = b_neg ? (~b + 1'b1) : b;

  // Multiply step: conditional add into the upper half with carry, then shift right.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);

  // Divide step: {rem, quot} shifted left; remainder never exceeds the divisor, so WIDTH bits suffice.
  assign rem_s    = acc_q[2*WIDTH-1:WIDTH-1];
  assign rem_diff = rem_s - {1'b0, mcand_q};
  assign rem_ge   = ~rem_diff[WIDTH];
  assign rem_n    = rem_ge ? rem_diff[WIDTH-1:0] : rem_s[WIDTH-1:0];

  always_comb begin
    acc_d = acc_q;
    if (is_div_q) acc_d = {rem_n, acc_q[WIDTH-2:0], rem_ge};
    else          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
  end

  // Divide-by-zero leaves |a| in the remainder, so the sign-corrected HI is already a.
  always_comb begin
    prod_s = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    fix_hi = prod_s[2*WIDTH-1:WIDTH];
    fix_lo = prod_s[WIDTH-1:0];
    if (is_div_q) begin
      fix_hi = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
      fix_lo = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
      if (dz_q) fix_lo = '1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      mcand_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_CALC;
            busy_q    <= 1'b1;
            is_div_q  <= op[1];
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dz_q      <= op[1] & (b == '0);
            mcand_q   <= op[1] ? b_mag : a_mag;
            acc_q     <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
            cnt_q     <= '0;
          end else begin
            if (mthi) hi_q <= a;
            if (mtlo) lo_q <= a;
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'(WIDTH-1)) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q       <= fix_hi;
          lo_q       <= fix_lo;
          done_q     <= 1'b1;
          div_zero_q <= dz_q;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized self-checking bench for mult_div_unit
module tb_mult_div_unit;

  logic        clk, rst, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {div_zero, hi, lo} from plain integer arithmetic.
  function automatic logic [64:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    int sx, sy;
    longint lx, ly;
    sx = x;
    sy = y;
    lx = sx;
    ly = sy;
    case (o)
      2'd0: p = 64'(lx * ly);
      2'd1: p = {32'd0, x} * {32'd0, y};
      2'd2: begin
        if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {1'b1 ^ 1'b1, 32'd0, 32'h8000_0000};
        p = {32'(sx % sy), 32'(sx / sy)};
      end
      default: begin
        if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
        p = {x % y, x / y};
      end
    endcase
    return {1'b0, p};
  endfunction

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, div_zero, hi, lo} !== 67'd0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b done=%b dz=%b hi=%h lo=%h, expected all 0", busy, done, div_zero, hi, lo);
    end
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
    logic [64:0] exp;
    int lat;
    exp = ref_model(o, x, y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL %s busy_after_start: got busy=%b done=%b, expected busy=1 done=0", tag, busy, done);
    end
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_cmp++;
    if (lat != 33 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s latency: got %0d cycles busy=%b, expected 33 cycles busy=0", tag, lat, busy);
    end
    n_cmp++;
    if ({div_zero, hi, lo} !== exp) begin
      n_err++;
      $display("FAIL %s result op=%0d a=%h b=%h: got dz=%b hi=%h lo=%h, expected dz=%b hi=%h lo=%h",
               tag, o, x, y, div_zero, hi, lo, exp[64], exp[63:32], exp[31:0]);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0 || div_zero !== 1'b0 || {hi, lo} !== exp[63:0]) begin
      n_err++;
      $display("FAIL %s done_pulse: got done=%b dz=%b hi=%h lo=%h, expected done=0 dz=0 result held", tag, done, div_zero, hi, lo);
    end
  endtask

  task automatic test_directed();
    test_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    test_op(2'd0, 32'hFFFF_FFFD, 32'd7, "mult_neg");
    test_op(2'd2, 32'hFFFF_FFF9, 32'd2, "div_neg");
    test_op(2'd3, 32'd100, 32'd0, "divu_zero");
    test_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    test_op(2'd2, 32'hFFFF_FFF0, 32'd0, "div_zero_neg");
    test_op(2'd0, 32'h8000_0000, 32'h8000_0000, "mult_min");
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = 32'($urandom_range(0, 9));
        1: y = -32'($urandom_range(1, 9));
        default: y = $urandom;
      endcase
      test_op(o, x, y, "random");
    end
  endtask

  task automatic test_moves();
    logic [31:0] old_lo;
    @(negedge clk);
    a = 32'h1234_5678; mthi = 1'b1;
    @(posedge clk);
    #1;
    mthi = 1'b0;
    n_cmp++;
    if (hi !== 32'h1234_5678 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL mthi: got hi=%h busy=%b done=%b, expected hi=12345678 busy=0 done=0", hi, busy, done);
    end
    @(negedge clk);
    a = 32'hCAFE_F00D; mthi = 1'b1; mtlo = 1'b1;
    @(posedge clk);
    #1;
    mthi = 1'b0; mtlo = 1'b0;
    n_cmp++;
    if (hi !== 32'hCAFE_F00D || lo !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL mthi_mtlo: got hi=%h lo=%h, expected both cafef00d", hi, lo);
    end
    old_lo = lo;
    @(negedge clk);
    op = 2'd1; a = 32'd6; b = 32'd9; start = 1'b1; mtlo = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; mtlo = 1'b0;
    n_cmp++;
    if (lo !== old_lo || busy !== 1'b1) begin
      n_err++;
      $display("FAIL start_over_mtlo: got lo=%h busy=%b, expected lo=%h busy=1", lo, busy, old_lo);
    end
    repeat (40) begin
      if (done === 1'b1) break;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (done !== 1'b1 || lo !== 32'd54 || hi !== 32'd0) begin
      n_err++;
      $display("FAIL start_over_mtlo_result: got done=%b hi=%h lo=%h, expected done=1 hi=0 lo=36", done, hi, lo);
    end
    @(posedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] old_hi, old_lo, x, y;
    logic [64:0] exp;
    int lat;
    old_hi = hi; old_lo = lo;
    @(negedge clk);
    op = 2'd3; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      start = (lat == 4);
      mthi  = (lat == 19);
      if (lat == 4)  begin op = 2'd1; a = 32'd5; b = 32'd5; end
      if (lat == 19) a = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      lat++;
      if (lat == 25) begin
        n_cmp++;
        if (hi !== old_hi || lo !== old_lo) begin
          n_err++;
          $display("FAIL hold_during_calc: got hi=%h lo=%h, expected hi=%h lo=%h", hi, lo, old_hi, old_lo);
        end
      end
    end
    start = 1'b0; mthi = 1'b0;
    n_cmp++;
    if (lat != 33 || lo !== 32'd142 || hi !== 32'd6) begin
      n_err++;
      $display("FAIL ignore_in_calc: got %0d cycles hi=%h lo=%h, expected 33 cycles hi=6 lo=8e", lat, hi, lo);
    end
    x = $urandom; y = $urandom;
    exp = ref_model(2'd0, x, y);
    op = 2'd0; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_accept: got busy=%b done=%b, expected busy=1 done=0", busy, done);
    end
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_cmp++;
    if (lat != 33 || {hi, lo} !== exp[63:0]) begin
      n_err++;
      $display("FAIL b2b_result: got %0d cycles hi=%h lo=%h, expected 33 cycles hi=%h lo=%h", lat, hi, lo, exp[63:32], exp[31:0]);
    end
    @(posedge clk);
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    op = 2'd0; a = $urandom; b = $urandom; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, div_zero, hi, lo} !== 67'd0) begin
      n_err++;
      $display("FAIL async_reset: got busy=%b done=%b dz=%b hi=%h lo=%h, expected all 0", busy, done, div_zero, hi, lo);
    end
    @(negedge clk);
    rst = 1'b1;
    test_op(2'd0, 32'hFFFF_FFFD, 32'd7, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_moves();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
